conv_encoder_k7: RTL and testbench



---
 rtl/conv_encoder_k7.sv | 127 ++++++++++++
 tb/tb_conv_encoder_k7.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_k7.sv
`default_nettype none
// ============================================================================
// Module   : conv_encoder_k7
// Brief    : Rate-1/2 K=7 (171/133) convolutional encoder with valid/ready
//            framing and K-1 zero tail bits per frame. Optional rate-2/3
//            puncture mask enabled by defining CONV_ENC_PUNCT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module conv_encoder_k7 #(
    parameter int           K  = 7,
    parameter logic [K-1:0] G0 = 7'o171,
    parameter logic [K-1:0] G1 = 7'o133
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [1:0] out_pair,
    output logic       out_valid,
    output logic       out_last,
`ifdef CONV_ENC_PUNCT_EN
    output logic [1:0] out_mask,
`endif
    input  logic       out_ready
);

    localparam int                  c_cnt_w     = $clog2(K - 1);
    localparam logic [c_cnt_w-1:0]  c_tail_last = c_cnt_w'(K - 2);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TAIL = 1'b1
    } state_t;

    state_t             r_state;
    logic [K-2:0]       r_sreg;      // [K-2] = most recent bit, [0] = oldest
    logic [c_cnt_w-1:0] r_tail_cnt;
    logic [1:0]         r_pair;
    logic               r_valid;
    logic               r_last;

    logic               w_adv;
    logic               w_accept;
    logic               w_u;
    logic               w_load;
    logic               w_tail_done;
    logic [K-1:0]       w_window;
    logic [1:0]         w_pair;

    assign w_adv       = !r_valid | out_ready;
    assign in_ready    = (r_state == ST_RUN) & w_adv;
    assign w_accept    = in_valid & in_ready;
    assign w_u         = (r_state == ST_RUN) ? in_bit : 1'b0;
    assign w_load      = w_accept | ((r_state == ST_TAIL) & w_adv);
    assign w_tail_done = (r_state == ST_TAIL) & (r_tail_cnt == c_tail_last);

    // Window bit K-1 is the current input, bit 0 the oldest tap.
    assign w_window    = {w_u, r_sreg};
    assign w_pair      = {^(w_window & G1), ^(w_window & G0)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_sreg     <= '0;
            r_tail_cnt <= '0;
            r_pair     <= 2'b00;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else if (w_adv) begin
            if (w_load) begin
                r_sreg  <= w_window[K-1:1];
                r_pair  <= w_pair;
                r_valid <= 1'b1;
                r_last  <= w_tail_done;
                case (r_state)
                    ST_RUN: begin
                        if (in_last) begin
                            r_state    <= ST_TAIL;
                            r_tail_cnt <= '0;
                        end
                    end
                    ST_TAIL: begin
                        if (w_tail_done) begin
                            r_state    <= ST_RUN;
                            r_tail_cnt <= '0;
                        end else begin
                            r_tail_cnt <= r_tail_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_RUN;
                endcase
            end else begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign out_pair  = r_pair;
    assign out_valid = r_valid;
    assign out_last  = r_last;

`ifdef CONV_ENC_PUNCT_EN
    // Phase tracks the parity of the next pair to be loaded; every loaded
    // pair is handshaken exactly once, so this follows the handshake count.
    logic       r_phase;
    logic [1:0] r_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_mask  <= 2'b00;
        end else if (w_adv && w_load) begin
            r_mask  <= r_phase ? 2'b01 : 2'b11;
            r_phase <= w_tail_done ? 1'b0 : ~r_phase;
        end
    end

    assign out_mask = r_mask;
`else
    // Rate 1/2: every pair is transmitted in full, no phase state.
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_k7.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_encoder_k7
// Brief    : Randomized self-checking bench for conv_encoder_k7 against a
//            convolution-sum reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_encoder_k7;

    localparam int       K     = 7;
    localparam bit [6:0] G0_T  = 7'o171;
    localparam bit [6:0] G1_T  = 7'o133;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [1:0] out_pair;
    logic       out_valid;
    logic       out_last;
    logic [1:0] out_mask;
    logic       out_ready = 1'b1;

    conv_encoder_k7 dut (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_pair  (out_pair),
        .out_valid (out_valid),
        .out_last  (out_last),
`ifdef CONV_ENC_PUNCT_EN
        .out_mask  (out_mask),
`endif
        .out_ready (out_ready)
    );

`ifndef CONV_ENC_PUNCT_EN
    assign out_mask = 2'b00;
`endif

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference model: pair n = XOR-convolution of the input history with
    // the generator taps (history index d=0 is the current bit).
    typedef struct {
        logic [1:0] pair;
        logic       last;
        logic [1:0] mask;
    } exp_t;

    bit   hist_q[$];
    exp_t exp_q[$];
    exp_t obs_q[$];
    int   pidx = 0;

    function automatic void model_push(input bit u, input bit last);
        exp_t e;
        bit   p0 = 1'b0;
        bit   p1 = 1'b0;
        hist_q.push_front(u);
        if (hist_q.size() > K) void'(hist_q.pop_back());
        for (int d = 0; d < hist_q.size(); d++) begin
            if (G0_T[K-1-d]) p0 ^= hist_q[d];
            if (G1_T[K-1-d]) p1 ^= hist_q[d];
        end
        e.pair = {p1, p0};
        e.last = last;
        e.mask = (pidx % 2 == 0) ? 2'b11 : 2'b01;
        pidx   = last ? 0 : pidx + 1;
        exp_q.push_back(e);
    endfunction

    logic       stall_prev = 1'b0;
    logic [1:0] prev_pair;
    logic       prev_last;
    int         n_notready = 0;
    logic       ready_at_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            hist_q.delete();
            exp_q.delete();
            pidx       = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_pair",  int'(out_pair),  int'(prev_pair));
                check("stall_last",  int'(out_last),  int'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pair", 1, 0);
                end else begin
                    exp_t e;
                    exp_t o;
                    e = exp_q.pop_front();
                    check("pair", int'(out_pair), int'(e.pair));
                    check("last", int'(out_last), int'(e.last));
`ifdef CONV_ENC_PUNCT_EN
                    check("mask", int'(out_mask), int'(e.mask));
`endif
                    o.pair = out_pair;
                    o.last = out_last;
                    o.mask = out_mask;
                    obs_q.push_back(o);
                end
                if (out_last) ready_at_last = in_ready;
            end
            stall_prev = out_valid && !out_ready;
            prev_pair  = out_pair;
            prev_last  = out_last;
            if (!in_ready) n_notready++;
            if (in_valid && in_ready) begin
                model_push(in_bit, 1'b0);
                if (in_last) begin
                    for (int t = 0; t < K - 1; t++) model_push(1'b0, t == K - 2);
                end
            end
        end
    end

    bit bp_mode = 1'b0;
    always @(posedge clk) begin
        #1 out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send_bit(input logic b, input logic last, input bit gaps);
        int t = 0;
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom_range(0, 1));
                in_last  = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        in_bit   = b;
        in_last  = last;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 1000) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int kind, input bit gaps);
        // kind: 0 = all zero, 1 = single one then zeros, 2 = random
        logic b;
        for (int i = 0; i < n; i++) begin
            b = (kind == 2) ? 1'($urandom_range(0, 1)) : ((kind == 1) && (i == 0));
            send_bit(b, i == n - 1, gaps);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
            t++;
            if (t > 2000) begin
                check("idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_impulse(input int base, input string tag);
        logic [1:0] imp [7];
        logic [1:0] msk [7];
        imp = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
        msk = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11};
        if (obs_q.size() < base + 7) begin
            check({tag, "_count"}, obs_q.size(), base + 7);
        end else begin
            for (int i = 0; i < 7; i++) begin
                check({tag, "_pair"}, int'(obs_q[base+i].pair), int'(imp[i]));
                check({tag, "_last"}, int'(obs_q[base+i].last), (i == 6) ? 1 : 0);
`ifdef CONV_ENC_PUNCT_EN
                check({tag, "_mask"}, int'(obs_q[base+i].mask), int'(msk[i]));
`endif
            end
        end
    endtask

    initial begin
        int total;
        int len;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_last",  int'(out_last),  0);
        check("rst_pair",  int'(out_pair),  0);
        check("rst_ready", int'(in_ready),  1);
`ifdef CONV_ENC_PUNCT_EN
        check("rst_mask",  int'(out_mask),  0);
`endif
        @(posedge clk); #1;

        // Impulse response
        obs_q.delete();
        n_notready = 0;
        send_frame(1, 1, 1'b0);
        wait_idle();
        check_impulse(0, "impulse");
        check("impulse_notready", n_notready, 6);

        // All-zero frame of 20 bits
        obs_q.delete();
        ready_at_last = 1'b0;
        send_frame(20, 0, 1'b0);
        wait_idle();
        check("zero_count", obs_q.size(), 26);
        for (int i = 0; i < obs_q.size(); i++) begin
            check("zero_pair", int'(obs_q[i].pair), 0);
            check("zero_last", int'(obs_q[i].last), (i == 25) ? 1 : 0);
        end
        check("zero_ready_after", int'(ready_at_last), 1);

        // Back-to-back impulse frames
        obs_q.delete();
        send_frame(1, 1, 1'b0);
        send_frame(1, 1, 1'b0);
        wait_idle();
        check("b2b_count", obs_q.size(), 14);
        check_impulse(0, "b2b_first");
        check_impulse(7, "b2b_second");

        // Backpressure on a 64-bit random frame
        obs_q.delete();
        bp_mode = 1'b1;
        send_frame(64, 2, 1'b1);
        wait_idle();
        check("bp_count", obs_q.size(), 70);

        // Random frames of random length, N=1 included
        obs_q.delete();
        total = 0;
        for (int f = 0; f < 6; f++) begin
            len = (f == 0) ? 1 : int'($urandom_range(1, 12));
            total += len + 6;
            send_frame(len, 2, 1'b1);
        end
        wait_idle();
        check("rand_count", obs_q.size(), total);
        bp_mode = 1'b0;
        @(posedge clk); #1;

        // Reset mid-frame after three accepted bits
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_ready", int'(in_ready),  1);
        @(posedge clk); #1;
        obs_q.delete();
        send_frame(1, 1, 1'b0);
        wait_idle();
        check_impulse(0, "midrst_impulse");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
